// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the bus signals around the data-memory port arbiter: the
// instruction-fetch requester (if_*), the load/store requester (ls_*) and
// the single memory port (mem_*).
//   slave  modport : arbiter view (requests and memory responses in,
//                    grants, responses and memory request fields out)
//   master modport : environment view (requesters plus memory model)
// Signal names keep their arbiter-relative _i/_o suffixes so that both
// sides agree on which way each wire points.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
  // Instruction-fetch requester
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  // Load/store requester
  logic        ls_req_i;
  logic        ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  // Memory port
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-ported data memory between instruction fetch (IF) and
// load/store (LS). One transaction is outstanding at a time:
//   IDLE  -> pick a winner, register its request fields, remember the owner
//   ISSUE -> hold mem_req_o until mem_gnt_i, pass the grant to the owner
//   WAIT  -> wait for mem_rvalid_i, pass the response to the owner
// LS wins contested arbitration unless IF has lost STARVE_MAX contested
// rounds in a row.
// Ports:
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (IF, LS and memory signals)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic       OWNER_IF     = 1'b0;
  localparam logic       OWNER_LS     = 1'b1;
  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  state_t      state_r;
  logic        owner_r;
  logic [3:0]  starve_cnt_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;

  logic        contested_s;
  logic        pick_ls_s;
  logic        issue_gnt_s;
  logic        wait_rvalid_s;

  // Arbitration decision, only consumed while in IDLE
  always_comb begin
    contested_s = bus.if_req_i & bus.ls_req_i;
    if (contested_s) begin
      pick_ls_s = (starve_cnt_r != STARVE_LIMIT);
    end else begin
      pick_ls_s = bus.ls_req_i;
    end
  end

  // Transaction FSM with registered memory request fields
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r      <= IDLE;
      owner_r      <= OWNER_IF;
      starve_cnt_r <= 4'd0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_be_r     <= 4'd0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.if_req_i || bus.ls_req_i) begin
            state_r   <= ISSUE;
            mem_req_r <= 1'b1;
            if (pick_ls_s) begin
              owner_r     <= OWNER_LS;
              mem_we_r    <= bus.ls_we_i;
              mem_be_r    <= bus.ls_be_i;
              mem_addr_r  <= bus.ls_addr_i;
              mem_wdata_r <= bus.ls_wdata_i;
              // Only a contested LS win counts against IF; STARVE_LIMIT
              // forces an IF win, so the counter never passes it.
              if (contested_s) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
              end else begin
                starve_cnt_r <= starve_cnt_r;
              end
            end else begin
              owner_r      <= OWNER_IF;
              mem_we_r     <= 1'b0;
              mem_be_r     <= 4'b1111;
              mem_addr_r   <= bus.if_addr_i;
              mem_wdata_r  <= 32'd0;
              starve_cnt_r <= 4'd0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (bus.mem_gnt_i) begin
            state_r   <= WAIT;
            mem_req_r <= 1'b0;
          end else begin
            state_r <= ISSUE;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid_i) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Route grant and response pulses to the owner only
  always_comb begin
    issue_gnt_s   = (state_r == ISSUE) && bus.mem_gnt_i;
    wait_rvalid_s = (state_r == WAIT)  && bus.mem_rvalid_i;
    if (owner_r == OWNER_LS) begin
      bus.ls_gnt_o    = issue_gnt_s;
      bus.ls_rvalid_o = wait_rvalid_s;
      bus.if_gnt_o    = 1'b0;
      bus.if_rvalid_o = 1'b0;
    end else begin
      bus.if_gnt_o    = issue_gnt_s;
      bus.if_rvalid_o = wait_rvalid_s;
      bus.ls_gnt_o    = 1'b0;
      bus.ls_rvalid_o = 1'b0;
    end
  end

  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.ls_rdata_o  = bus.mem_rdata_i;
  assign bus.mem_req_o   = mem_req_r;
  assign bus.mem_we_o    = mem_we_r;
  assign bus.mem_be_o    = mem_be_r;
  assign bus.mem_addr_o  = mem_addr_r;
  assign bus.mem_wdata_o = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.slave)
  );

  typedef struct packed {
    logic        owner_ls;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic idle_inputs();
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'd0;
    bus.ls_req_i    = 1'b0;
    bus.ls_we_i     = 1'b0;
    bus.ls_be_i     = 4'd0;
    bus.ls_addr_i   = 32'd0;
    bus.ls_wdata_i  = 32'd0;
    bus.mem_gnt_i   = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = 32'd0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    sb_q.delete();
    #1;
  endtask

  // Push the expected transaction built from the winner's current inputs
  task automatic push_txn(input bit ls, input logic [31:0] rdata);
    txn_t e;
    e.owner_ls = ls;
    e.we    = ls ? bus.ls_we_i : 1'b0;
    e.be    = ls ? bus.ls_be_i : 4'b1111;
    e.addr  = ls ? bus.ls_addr_i : bus.if_addr_i;
    e.wdata = ls ? bus.ls_wdata_i : 32'd0;
    e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  // Act as the memory for one transaction and compare against the scoreboard
  task automatic serve(input int gd, input int rd, input bit keep);
    txn_t e;
    int n;
    logic [3:0] exp_pulse;
    n = 0;
    while (bus.mem_req_o !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    tests_run++;
    if (bus.mem_req_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL serve_timeout: mem_req_o=%b required 1", bus.mem_req_o);
      return;
    end
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL sb_empty: request seen with no expected transaction");
      return;
    end
    e = sb_q.pop_front();
    for (int k = 0; k <= gd; k++) begin
      bus.mem_gnt_i = (k == gd);
      #1;
      tests_run++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== e.we || bus.mem_be_o !== e.be ||
          bus.mem_addr_o !== e.addr || (e.owner_ls && bus.mem_wdata_o !== e.wdata)) begin
        tests_failed++;
        $display("FAIL issue_fields: req=%b we=%b be=%b addr=%h wdata=%h required 1 %b %b %h %h",
                 bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o,
                 e.we, e.be, e.addr, e.wdata);
      end
      exp_pulse = (k == gd) ? (e.owner_ls ? 4'b0100 : 4'b1000) : 4'b0000;
      tests_run++;
      if ({bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.ls_rvalid_o} !== exp_pulse) begin
        tests_failed++;
        $display("FAIL issue_pulses: {ifg,lsg,ifv,lsv}=%b required %b",
                 {bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.ls_rvalid_o}, exp_pulse);
      end
      @(negedge clk);
    end
    bus.mem_gnt_i = 1'b0;
    if (!keep) begin
      if (e.owner_ls) bus.ls_req_i = 1'b0;
      else            bus.if_req_i = 1'b0;
    end
    for (int k = 0; k <= rd; k++) begin
      bus.mem_rvalid_i = (k == rd);
      bus.mem_rdata_i  = (k == rd) ? e.rdata : 32'($urandom);
      #1;
      tests_run++;
      if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== e.addr || bus.mem_be_o !== e.be) begin
        tests_failed++;
        $display("FAIL wait_fields: req=%b addr=%h be=%b required 0 %h %b",
                 bus.mem_req_o, bus.mem_addr_o, bus.mem_be_o, e.addr, e.be);
      end
      exp_pulse = (k == rd) ? (e.owner_ls ? 4'b0001 : 4'b0010) : 4'b0000;
      tests_run++;
      if ({bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.ls_rvalid_o} !== exp_pulse) begin
        tests_failed++;
        $display("FAIL wait_pulses: {ifg,lsg,ifv,lsv}=%b required %b",
                 {bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.ls_rvalid_o}, exp_pulse);
      end
      if (k == rd) begin
        tests_run++;
        if ((e.owner_ls ? bus.ls_rdata_o : bus.if_rdata_o) !== e.rdata) begin
          tests_failed++;
          $display("FAIL rdata: %h required %h",
                   e.owner_ls ? bus.ls_rdata_o : bus.if_rdata_o, e.rdata);
        end
      end
      @(negedge clk);
    end
    bus.mem_rvalid_i = 1'b0;
    #1;
  endtask

  // One arbitration round: expected owner and starve count come from the test
  task automatic arb_serve(input bit exp_ls, input int exp_starve, input int gd,
                           input int rd, input bit keep, input logic [31:0] rdata);
    push_txn(exp_ls, rdata);
    serve(gd, rd, keep);
    tests_run++;
    if (dut.starve_cnt_r !== 4'(exp_starve)) begin
      tests_failed++;
      $display("FAIL starve_cnt: %0d required %0d", dut.starve_cnt_r, exp_starve);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    tests_run++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== 70'd0) begin
      tests_failed++;
      $display("FAIL reset_mem: req=%b we=%b be=%b addr=%h wdata=%h required all 0",
               bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    tests_run++;
    if ({bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.ls_rvalid_o} !== 4'd0 ||
        2'(dut.state_r) !== 2'd0 || dut.starve_cnt_r !== 4'd0 || dut.owner_r !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: pulses=%b state=%0d starve=%0d owner=%b required 0 0 0 0",
               {bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.ls_rvalid_o},
               2'(dut.state_r), dut.starve_cnt_r, dut.owner_r);
    end
  endtask

  task automatic test_single_if();
    reset_dut();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0010;
    arb_serve(1'b0, 0, 0, 0, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic test_ls_write_wait();
    reset_dut();
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'b1;
    bus.ls_be_i    = 4'b0011;
    bus.ls_addr_i  = 32'h0000_0020;
    bus.ls_wdata_i = 32'h0000_1234;
    arb_serve(1'b1, 0, 2, 3, 1'b0, 32'h0BAD_F00D);
  endtask

  task automatic test_contention();
    reset_dut();
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 32'h0000_1000;
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'b0;
    bus.ls_be_i    = 4'b1100;
    bus.ls_addr_i  = 32'h0000_2000;
    bus.ls_wdata_i = 32'h5555_AAAA;
    for (int i = 0; i < 10; i++) begin
      arb_serve((i % 5) != 4, ((i % 5) != 4) ? (i % 5) + 1 : 0,
                i % 2, (i / 2) % 2, 1'b1, 32'($urandom));
    end
    bus.if_req_i = 1'b0;
    bus.ls_req_i = 1'b0;
  endtask

  task automatic test_uncontested_ls();
    reset_dut();
    bus.ls_req_i  = 1'b1;
    bus.ls_be_i   = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      bus.ls_addr_i = 32'h0000_0300 + 32'(i * 4);
      arb_serve(1'b1, 0, 0, 0, 1'b1, 32'($urandom));
    end
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0400;
    arb_serve(1'b1, 1, 0, 0, 1'b0, 32'($urandom));
    arb_serve(1'b0, 0, 1, 0, 1'b0, 32'($urandom));
  endtask

  task automatic test_reset_in_wait();
    reset_dut();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0044;
    @(negedge clk); #1;
    tests_run++;
    if (bus.mem_req_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_wait_req: mem_req_o=%b required 1", bus.mem_req_o);
    end
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    bus.if_req_i  = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    tests_run++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== 70'd0 ||
        2'(dut.state_r) !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_wait_regs: req=%b addr=%h be=%b state=%0d required 0 0 0 0",
               bus.mem_req_o, bus.mem_addr_o, bus.mem_be_o, 2'(dut.state_r));
    end
    @(negedge clk);
    rstn = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hCAFE_0001;
    #1;
    tests_run++;
    if ({bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_gnt_o, bus.ls_gnt_o} !== 4'd0) begin
      tests_failed++;
      $display("FAIL rst_wait_drop: pulses=%b required 0000",
               {bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_gnt_o, bus.ls_gnt_o});
    end
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    tests_run++;
    if (2'(dut.state_r) !== 2'd0 || bus.mem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_wait_idle: state=%0d req=%b required 0 0", 2'(dut.state_r), bus.mem_req_o);
    end
  endtask

  task automatic test_spurious();
    reset_dut();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_gnt_i    = 1'b1;
    #1;
    tests_run++;
    if ({bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.ls_rvalid_o} !== 4'd0) begin
      tests_failed++;
      $display("FAIL spur_idle_pulse: pulses=%b required 0000",
               {bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.ls_rvalid_o});
    end
    @(negedge clk); #1;
    tests_run++;
    if (2'(dut.state_r) !== 2'd0 || bus.mem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL spur_idle_state: state=%0d req=%b required 0 0", 2'(dut.state_r), bus.mem_req_o);
    end
    bus.mem_gnt_i = 1'b0;
    bus.ls_req_i  = 1'b1;
    bus.ls_be_i   = 4'b1111;
    bus.ls_addr_i = 32'h0000_0030;
    @(negedge clk); #1;
    repeat (2) begin
      tests_run++;
      if (2'(dut.state_r) !== 2'd1 || bus.mem_req_o !== 1'b1 ||
          {bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_gnt_o, bus.ls_gnt_o} !== 4'd0) begin
        tests_failed++;
        $display("FAIL spur_issue: state=%0d req=%b pulses=%b required 1 1 0000",
                 2'(dut.state_r), bus.mem_req_o,
                 {bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_gnt_o, bus.ls_gnt_o});
      end
      @(negedge clk); #1;
    end
    bus.mem_rvalid_i = 1'b0;
    arb_serve(1'b1, 0, 0, 1, 1'b0, 32'h7777_1234);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_if();
    test_ls_write_wait();
    test_contention();
    test_uncontested_ls();
    test_reset_in_wait();
    test_spurious();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: %0d entries required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single-ported data memory between the instruction-fetch requester (IF) and the load/store requester (LS). It arbitrates between the two, registers the winning request, and drives the memory request/grant/response handshake. It then routes the response back to the owning requester. It sits between the IF/MEM pipeline stages and the memory model, and allows one outstanding transaction at a time.

## Interface
Parameters:
- STARVE_MAX, 4: number of consecutive contested LS wins after which IF is forced to win the next contested arbitration (1..15).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rstn_i  in  1  reset, asynchronous, active-low; clock clk_i
- if_req_i  in  1  IF read request; held with if_addr_i stable until if_gnt_o
- if_addr_i  in  32  IF byte address
- if_gnt_o  out  1  IF request accepted by memory (1-cycle pulse)
- if_rvalid_o  out  1  IF read data valid (1-cycle pulse)
- if_rdata_o  out  32  IF read data; equals mem_rdata_i, meaningful only with if_rvalid_o
- ls_req_i  in  1  LS request; held with all LS fields stable until ls_gnt_o
- ls_we_i  in  1  1 = write, 0 = read
- ls_be_i  in  4  byte enables
- ls_addr_i  in  32  LS byte address
- ls_wdata_i  in  32  LS write data
- ls_gnt_o  out  1  LS request accepted (1-cycle pulse)
- ls_rvalid_o  out  1  LS completion; read data valid for reads, write-done for writes
- ls_rdata_o  out  32  equals mem_rdata_i
- mem_req_o  out  1  memory request
- mem_we_o, mem_be_o[3:0], mem_addr_o[31:0], mem_wdata_o[31:0]  out  request fields, registered
- mem_gnt_i  in  1  memory accepted the request this cycle
- mem_rvalid_i  in  1  memory response valid this cycle
- mem_rdata_i  in  32  memory response data

## Operation
- FSM states: IDLE, ISSUE, WAIT. An owner register holds IF or LS.
- IDLE: if either request is high, select a winner, latch its fields into the mem_* registers, set the owner, and move to ISSUE. IF requests latch we=0 and be=4'b1111. With no request, stay in IDLE.
- Priority when both requests are high (contested): LS wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
- starve_cnt (4 bits):
  - increments on each contested LS win;
  - clears on any IF win;
  - holds on an uncontested LS win.
- ISSUE: mem_req_o = 1. When mem_gnt_i = 1, pulse the owner's gnt_o in the same cycle (combinational) and move to WAIT. Otherwise hold mem_req_o and the fields.
- WAIT: mem_req_o = 0. When mem_rvalid_i = 1, pulse the owner's rvalid_o in the same cycle (combinational) and move to IDLE.
- The non-owner's gnt_o and rvalid_o stay 0 at all times.
- mem_gnt_i outside ISSUE is ignored. mem_rvalid_i outside WAIT is ignored and must not produce any rvalid_o.
- A request that arrives while the FSM is busy waits; requesters keep req high until gnt.
- Reset mid-transaction: the transaction is abandoned and any later mem_rvalid_i for it is dropped, because the FSM is in IDLE.

## Timing
- Reset values:
  - state IDLE, owner IF, starve_cnt 0;
  - mem_req_o, mem_we_o 0; mem_be_o 0; mem_addr_o, mem_wdata_o 0;
  - all gnt_o and rvalid_o 0.
- A request sampled in IDLE at edge T puts mem_req_o high from T+1.
- With zero wait states, mem_gnt_i and gnt_o fall at T+1, and mem_rvalid_i and rvalid_o at T+2 at the earliest. The FSM is back in IDLE at T+3.
- Throughput is at most one transaction per 3 cycles.
- Each wait-state cycle on mem_gnt_i or mem_rvalid_i adds exactly one cycle.
- Arbitration happens only in IDLE. Requests that arrive in ISSUE or WAIT are evaluated at the first IDLE cycle.

## Test plan
- Single IF read: if_req_i=1, addr 0x10; memory grants immediately and returns 0xDEADBEEF one cycle later. Expected: mem_req_o at T+1 with addr 0x10, be 1111, we 0; if_gnt_o at T+1; if_rvalid_o with rdata 0xDEADBEEF at T+2; ls_* outputs stay 0.
- LS write with wait states: ls_we_i=1, be 0011, addr 0x20, wdata 0x1234; mem_gnt_i delayed 2 cycles, mem_rvalid_i delayed 3 cycles. Expected: fields held stable throughout; exactly one ls_gnt_o pulse and one ls_rvalid_o pulse.
- Contention and starvation with STARVE_MAX=4: both requesters always requesting. Expected grant order LS, LS, LS, LS, IF, then repeating; starve_cnt reads 0 after each IF win.
- Uncontested LS wins: LS alone wins 6 times, then IF and LS both request. Expected: LS wins, since starve_cnt is still 0.
- Reset in WAIT: assert rstn_i=0 mid-transaction, release it, then pulse mem_rvalid_i. Expected: no rvalid_o, state IDLE, all outputs at reset values.
- Spurious response: mem_rvalid_i=1 while in IDLE or ISSUE. Expected: no rvalid_o pulse and no state change.
